fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter IMEM_AW, default 10, instruction-memory address width in words.
REQ-002 clock  input  1  processor clock; all state updates on posedge clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 pc  input  32  current program counter as held by the datapath.
REQ-005 imem_en  output  1  instruction-memory read strobe.
REQ-006 imem_addr  output  IMEM_AW  instruction word address.
REQ-007 imem_rdata  input  32  instruction word, valid exactly one cycle after imem_en.
REQ-008 issue_valid  output  1  decoded fields valid for the datapath.
REQ-009 issue_ready  input  1  datapath accepts the issued instruction.
REQ-010 alucode 5, pcControl 4, op1 3, op2 21, imControl 1, flag 1, flag1 1, writecode 1: all outputs, datapath control fields.
REQ-011 halted  output  1  block stopped; only reset restarts it.
REQ-012 illegal  output  1  last issued or fetched instruction was undecodable or out of range.

Function
REQ-013 Instruction format SHALL be: [31:27] opcode, [26] imControl, [25] flag, [24] flag1, [23:21] op1, [20:0] op2.
REQ-014 FSM states SHALL be FETCH, WAIT, DECODE, ISSUE, HALTED.
REQ-015 FETCH: if pc[31:IMEM_AW] is nonzero, go to HALTED with illegal=1 and no read; otherwise drive imem_en=1 and imem_addr=pc[IMEM_AW-1:0] for one cycle, then go to WAIT.
REQ-016 WAIT: capture imem_rdata into the instruction register, then go to DECODE.
REQ-017 DECODE: register all control fields from the instruction register in one cycle, then go to ISSUE.
REQ-018 ISSUE: hold issue_valid=1 and all fields stable until issue_ready=1; on the accepting cycle go to HALTED if the opcode is HALT, else to FETCH.
REQ-019 Fetch-to-issue latency SHALL be 3 cycles (FETCH, WAIT, DECODE); issue_valid rises on the 4th cycle.
REQ-020 Opcodes 0-11: alucode=opcode, pcControl=0, writecode=0.
REQ-021 Opcode 12 (MOV): alucode=0, pcControl=0, writecode=1.
REQ-022 Opcodes 13-20 (branches): pcControl=opcode-12 (1..8), alucode=0, writecode=0.
REQ-023 Opcode 21 (JR): pcControl=9. Opcode 22 (HALT): pcControl=10. Both with alucode=0 and writecode=0.
REQ-024 Opcodes 23-31: issue as NOP with all control fields 0 and illegal=1.
REQ-025 illegal SHALL update at each DECODE and hold its value until the next DECODE or reset.
REQ-026 op1, op2, imControl, flag and flag1 SHALL pass bit-exact from the instruction for all legal opcodes.
REQ-027 issue_ready while not in ISSUE SHALL be ignored.
REQ-028 HALTED: issue_valid=0 and imem_en=0; remain in HALTED until reset.
REQ-029 pc SHALL be sampled only in FETCH, so the datapath PC update on the acceptance cycle takes effect on the next fetch.

Reset
REQ-030 When reset=1 at a posedge, the FSM SHALL enter FETCH and all outputs SHALL go to 0 (including halted and illegal).
REQ-031 Reset in any state (including ISSUE with valid high, or WAIT with a read in flight) SHALL discard the in-flight instruction.
REQ-032 Reset SHALL have priority over issue_ready.

Structure
REQ-033 Opcode constants (ALU 0-11, MOV=12, BR base=13, JR=21, HALT=22), the pcControl encodings and the FSM state encoding SHALL reside in a shared package, j17_isa_pkg.
REQ-034 The opcode-to-control mapping SHALL be a separate combinational sub-module, j17_opdecode; the FSM and registers SHALL reside in fetch_decode.

Verification
REQ-035 Reset, pc=0, mem[0]=0x08200005 (opcode 1, op1=1, op2=5) -> imem_addr=0 in cycle 1; issue_valid in cycle 4 with alucode=1, op1=1, op2=5, pcControl=0.
REQ-036 Hold issue_ready=0 for 5 cycles in ISSUE -> issue_valid and all fields stable throughout; no imem_en; fetch follows the cycle after ready.
REQ-037 mem[3] with opcode 15 -> pcControl=3; mem[4] with opcode 22 -> pcControl=10, then halted=1, and issue_valid stays 0 for 20 cycles.
REQ-038 Opcode 27 -> all control fields 0, illegal=1; the next legal instruction clears illegal.
REQ-039 pc=0x400 with IMEM_AW=10 -> no imem_en, halted=1, illegal=1.
REQ-040 Reset asserted in WAIT and separately in ISSUE -> outputs 0 on the next cycle and a fresh fetch of the current pc.

Source files
------------

// File: rtl/j17_isa_pkg.sv
// J17 instruction-set constants shared by the fetch/decode FSM and the
// opcode decoder: opcode map, pcControl encodings, FSM states and the
// registered control word handed to the datapath.
package j17_isa_pkg;

   // Opcode map (instruction bits [31:27])
   localparam logic [4:0] OP_ALU_LAST = 5'd11;  // 0..11 are plain ALU ops
   localparam logic [4:0] OP_MOV      = 5'd12;
   localparam logic [4:0] OP_BR_BASE  = 5'd13;  // 13..20 are branches
   localparam logic [4:0] OP_BR_LAST  = 5'd20;
   localparam logic [4:0] OP_JR       = 5'd21;
   localparam logic [4:0] OP_HALT     = 5'd22;

   // pcControl encodings; branches use 1..8 (opcode - OP_MOV)
   localparam logic [3:0] PC_SEQ  = 4'd0;
   localparam logic [3:0] PC_JR   = 4'd9;
   localparam logic [3:0] PC_HALT = 4'd10;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_HALTED = 3'd4
   } fd_state_t;

   // Control word registered in DECODE and held through ISSUE
   typedef struct packed {
      logic [4:0]  alucode;
      logic [3:0]  pc_control;
      logic [2:0]  op1;
      logic [20:0] op2;
      logic        im_control;
      logic        flag;
      logic        flag1;
      logic        writecode;
   } ctrl_t;

endpackage

// File: rtl/fetch_decode_if.sv
// Bus between fetch_decode and its environment: instruction-memory read
// port, PC input, and the issue handshake with the decoded control fields.
interface fetch_decode_if #(parameter int IMEM_AW = 10);
   logic [31:0]        pc;
   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               issue_valid;
   logic               issue_ready;
   logic [4:0]         alucode;
   logic [3:0]         pcControl;
   logic [2:0]         op1;
   logic [20:0]        op2;
   logic               imControl;
   logic               flag;
   logic               flag1;
   logic               writecode;
   logic               halted;
   logic               illegal;

   modport master (
      input  pc, imem_rdata, issue_ready,
      output imem_en, imem_addr, issue_valid, alucode, pcControl, op1, op2,
             imControl, flag, flag1, writecode, halted, illegal
   );

   modport slave (
      output pc, imem_rdata, issue_ready,
      input  imem_en, imem_addr, issue_valid, alucode, pcControl, op1, op2,
             imControl, flag, flag1, writecode, halted, illegal
   );
endinterface

// File: rtl/j17_opdecode.sv
// Combinational opcode-to-control mapping for the J17 ISA.
module j17_opdecode
   import j17_isa_pkg::*;
(
   input  logic [4:0] opcode,
   output logic [4:0] alucode,
   output logic [3:0] pc_control,
   output logic       writecode,
   output logic       legal
);

   // map the opcode onto ALU / PC / write-back controls
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      alucode    = '0;
      pc_control = PC_SEQ;
      writecode  = 1'b0;
      legal      = 1'b1;
      if (opcode <= OP_ALU_LAST) begin
         alucode = opcode;
      end else if (opcode == OP_MOV) begin
         writecode = 1'b1;
      end else if (opcode >= OP_BR_BASE && opcode <= OP_BR_LAST) begin
         pc_control = 4'(opcode - OP_MOV);
      end else if (opcode == OP_JR) begin
         pc_control = PC_JR;
      end else if (opcode == OP_HALT) begin
         pc_control = PC_HALT;
      end else begin
         legal = 1'b0;
      end
   end

endmodule

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode front end: FETCH -> WAIT -> DECODE -> ISSUE,
// one instruction in flight, stops in HALTED on HALT or an out-of-range PC.
module fetch_decode #(
   parameter int IMEM_AW = 10
) (
   input logic            clock,
   input logic            reset,
   fetch_decode_if.master bus
);
   import j17_isa_pkg::*;

   fd_state_t          state, state_nxt;
   logic [31:0]        ir;
   ctrl_t              ctrl_q, ctrl_d;
   logic               illegal_q;
   logic               ir_load, ctrl_load, oob_stop, pc_oob;
   logic               fetch_en;
   logic [IMEM_AW-1:0] fetch_addr;
   logic [4:0]         dec_alucode;
   logic [3:0]         dec_pc_control;
   logic               dec_writecode, dec_legal;

   assign pc_oob = |bus.pc[31:IMEM_AW];

   j17_opdecode u_opdecode (
      .opcode     (ir[31:27]),
      .alucode    (dec_alucode),
      .pc_control (dec_pc_control),
      .writecode  (dec_writecode),
      .legal      (dec_legal)
   );

   // control word for the held instruction; undecodable opcodes become a NOP
   always_comb begin
      ctrl_d = '0;
      if (dec_legal) begin
         ctrl_d.alucode    = dec_alucode;
         ctrl_d.pc_control = dec_pc_control;
         ctrl_d.writecode  = dec_writecode;
         ctrl_d.im_control = ir[26];
         ctrl_d.flag       = ir[25];
         ctrl_d.flag1      = ir[24];
         ctrl_d.op1        = ir[23:21];
         ctrl_d.op2        = ir[20:0];
      end
   end

   // state register; reset restarts at FETCH and drops any in-flight work
   always_ff @(posedge clock) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= ST_FETCH;
      else       state <= state_nxt;
   end

   // next-state logic and per-state strobes
   always_comb begin
      state_nxt  = state;
      fetch_en   = 1'b0;
      fetch_addr = '0;
      ir_load    = 1'b0;
      ctrl_load  = 1'b0;
      oob_stop   = 1'b0;
      case (state)
         ST_FETCH: begin
            if (pc_oob) begin
               oob_stop  = 1'b1;
               state_nxt = ST_HALTED;
            end else begin
               // no read strobe while reset is being applied
               fetch_en   = ~reset;
               fetch_addr = bus.pc[IMEM_AW-1:0];
               state_nxt  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            ir_load   = 1'b1;
            state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            ctrl_load = 1'b1;
            state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (bus.issue_ready)
               state_nxt = (ir[31:27] == OP_HALT) ? ST_HALTED : ST_FETCH;
         end
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_FETCH;
      endcase
   end

   // instruction register, decoded control word and sticky illegal flag
   always_ff @(posedge clock) begin
      if (reset) begin
         ir        <= '0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (ir_load) ir <= bus.imem_rdata;
         if (ctrl_load) begin
            ctrl_q    <= ctrl_d;
            illegal_q <= ~dec_legal;
         end else if (oob_stop) begin
            illegal_q <= 1'b1;
         end
      end
   end

   assign bus.imem_en     = fetch_en;
   assign bus.imem_addr   = fetch_addr;
   assign bus.issue_valid = (state == ST_ISSUE);
   assign bus.halted      = (state == ST_HALTED);
   assign bus.illegal     = illegal_q;
   assign bus.alucode     = ctrl_q.alucode;
   assign bus.pcControl   = ctrl_q.pc_control;
   assign bus.op1         = ctrl_q.op1;
   assign bus.op2         = ctrl_q.op2;
   assign bus.imControl   = ctrl_q.im_control;
   assign bus.flag        = ctrl_q.flag;
   assign bus.flag1       = ctrl_q.flag1;
   assign bus.writecode   = ctrl_q.writecode;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: hand-computed instruction vectors, an
// expected-issue queue filled by the stimulus and drained by a monitor.
module tb_fetch_decode;

   typedef struct {
      logic [4:0]  alucode;
      logic [3:0]  pcc;
      logic [2:0]  op1;
      logic [20:0] op2;
      logic        im;
      logic        flag;
      logic        flag1;
      logic        wr;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   logic [31:0] mem [0:1023];

   fetch_decode_if #(.IMEM_AW(10)) bus ();

   fetch_decode #(.IMEM_AW(10)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // instruction memory: data one cycle after the read strobe
   always @(posedge clk)
      if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

   function automatic exp_t mk(input logic [4:0] alu, input logic [3:0] pcc,
                               input logic [2:0] o1, input logic [20:0] o2,
                               input logic im, input logic f, input logic f1,
                               input logic wr, input logic ill);
      exp_t e;
      e.alucode = alu; e.pcc = pcc; e.op1 = o1; e.op2 = o2;
      e.im = im; e.flag = f; e.flag1 = f1; e.wr = wr; e.ill = ill;
      return e;
   endfunction

   function automatic logic [31:0] enc(input logic [4:0] opc, input logic im,
                                       input logic f, input logic f1,
                                       input logic [2:0] o1, input logic [20:0] o2);
      return {opc, im, f, f1, o1, o2};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_fields(input string tag, input exp_t e);
      check({tag, ".alucode"},   32'(bus.alucode),   32'(e.alucode));
      check({tag, ".pcControl"}, 32'(bus.pcControl), 32'(e.pcc));
      check({tag, ".op1"},       32'(bus.op1),       32'(e.op1));
      check({tag, ".op2"},       32'(bus.op2),       32'(e.op2));
      check({tag, ".imControl"}, 32'(bus.imControl), 32'(e.im));
      check({tag, ".flag"},      32'(bus.flag),      32'(e.flag));
      check({tag, ".flag1"},     32'(bus.flag1),     32'(e.flag1));
      check({tag, ".writecode"}, 32'(bus.writecode), 32'(e.wr));
      check({tag, ".illegal"},   32'(bus.illegal),   32'(e.ill));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.issue_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   // Starts in FETCH; fetches word p, expects issue after 3 cycles, holds
   // ready low for 'delay' cycles, then accepts.
   task automatic run_instr(input logic [31:0] p, input exp_t e, input int delay,
                            input bit is_halt);
      int cnt = 0;
      bus.pc = p;
      #1;
      check("fetch.imem_en", 32'(bus.imem_en), 1);
      check("fetch.imem_addr", 32'(bus.imem_addr), p & 32'h3FF);
      sb.push_back(e);
      while (!bus.issue_valid && cnt < 8) begin
         tick();
         cnt++;
      end
      check("issue.latency", cnt, 3);
      for (int i = 0; i <= delay; i++) begin
         check("hold.issue_valid", 32'(bus.issue_valid), 1);
         check("hold.imem_en", 32'(bus.imem_en), 0);
         check_fields("hold", e);
         if (i < delay) tick();
      end
      bus.issue_ready = 1'b1;
      tick();
      bus.issue_ready = 1'b0;
      #1;
      if (is_halt) begin
         bit seen_valid = 1'b0, seen_en = 1'b0, left_halt = 1'b0;
         check("halt.halted", 32'(bus.halted), 1);
         bus.issue_ready = 1'b1;   // must be ignored outside ISSUE
         for (int i = 0; i < 20; i++) begin
            seen_valid |= bus.issue_valid;
            seen_en    |= bus.imem_en;
            left_halt  |= ~bus.halted;
            tick();
         end
         bus.issue_ready = 1'b0;
         check("halt.valid_seen", 32'(seen_valid), 0);
         check("halt.imem_en_seen", 32'(seen_en), 0);
         check("halt.left_halted", 32'(left_halt), 0);
      end else begin
         check("next.imem_en", 32'(bus.imem_en), 1);
         check("next.issue_valid", 32'(bus.issue_valid), 0);
      end
   endtask

   // scoreboard monitor: compare each accepted issue with the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (bus.issue_valid && bus.issue_ready && !reset) begin
            if (sb.size() == 0) check("sb.pending", 32'(sb.size()), 1);
            else check_fields("sb", sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      exp_t e_zero_ill;
      bit   seen_en;
      e_zero_ill = mk(5'd0, 4'd0, 3'd0, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0] = 32'h0820_0005;
      mem[1] = enc(5'd12, 1'b1, 1'b0, 1'b1, 3'd5, 21'h1ABCD);
      mem[2] = enc(5'd27, 1'b1, 1'b1, 1'b1, 3'd7, 21'h1FFFFF);
      mem[3] = enc(5'd15, 1'b0, 1'b1, 1'b0, 3'd2, 21'h00100);
      mem[4] = enc(5'd22, 1'b0, 1'b0, 1'b0, 3'd0, 21'h0);
      mem[5] = enc(5'd11, 1'b1, 1'b1, 1'b0, 3'd3, 21'h0A5A5);
      mem[6] = enc(5'd20, 1'b0, 1'b0, 1'b1, 3'd6, 21'h12345);
      mem[7] = enc(5'd21, 1'b0, 1'b0, 1'b0, 3'd4, 21'h00042);
      mem[8] = enc(5'd23, 1'b1, 1'b0, 1'b0, 3'd1, 21'h00001);
      mem[9] = enc(5'd13, 1'b0, 1'b0, 1'b0, 3'd0, 21'h00007);

      bus.pc = 32'h0;
      bus.issue_ready = 1'b0;
      do_reset();
      check("rst.issue_valid", 32'(bus.issue_valid), 0);
      check("rst.halted", 32'(bus.halted), 0);
      check("rst.illegal", 32'(bus.illegal), 0);
      check("rst.alucode", 32'(bus.alucode), 0);
      check("rst.writecode", 32'(bus.writecode), 0);

      // instruction stream ending with HALT
      run_instr(32'd0, mk(5'd1,  4'd0, 3'd1, 21'h5,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 5, 1'b0);
      run_instr(32'd1, mk(5'd0,  4'd0, 3'd5, 21'h1ABCD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 1, 1'b0);
      run_instr(32'd2, e_zero_ill, 0, 1'b0);
      run_instr(32'd3, mk(5'd0,  4'd3, 3'd2, 21'h00100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 0, 1'b0);
      run_instr(32'd5, mk(5'd11, 4'd0, 3'd3, 21'h0A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 2, 1'b0);
      run_instr(32'd6, mk(5'd0,  4'd8, 3'd6, 21'h12345, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 0, 1'b0);
      run_instr(32'd7, mk(5'd0,  4'd9, 3'd4, 21'h00042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0);
      run_instr(32'd8, e_zero_ill, 1, 1'b0);
      run_instr(32'd9, mk(5'd0,  4'd1, 3'd0, 21'h00007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0);
      run_instr(32'd4, mk(5'd0,  4'd10, 3'd0, 21'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b1);

      // reset while a read is in flight (WAIT)
      do_reset();
      bus.pc = 32'd1;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_wait.issue_valid", 32'(bus.issue_valid), 0);
      check("rst_wait.imem_en", 32'(bus.imem_en), 1);
      check("rst_wait.imem_addr", 32'(bus.imem_addr), 1);
      run_instr(32'd1, mk(5'd0, 4'd0, 3'd5, 21'h1ABCD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 0, 1'b0);

      // reset while issuing, with ready high in the same cycle
      bus.pc = 32'd5;
      tick();
      tick();
      tick();
      check("pre_rst_issue.issue_valid", 32'(bus.issue_valid), 1);
      reset = 1'b1;
      bus.issue_ready = 1'b1;
      tick();
      reset = 1'b0;
      bus.issue_ready = 1'b0;
      #1;
      check("rst_issue.issue_valid", 32'(bus.issue_valid), 0);
      check("rst_issue.alucode", 32'(bus.alucode), 0);
      check("rst_issue.op2", 32'(bus.op2), 0);
      check("rst_issue.imControl", 32'(bus.imControl), 0);
      check("rst_issue.halted", 32'(bus.halted), 0);
      check("rst_issue.imem_en", 32'(bus.imem_en), 1);
      check("rst_issue.imem_addr", 32'(bus.imem_addr), 5);
      run_instr(32'd5, mk(5'd11, 4'd0, 3'd3, 21'h0A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 0, 1'b0);

      // out-of-range PC stops without a read
      do_reset();
      bus.pc = 32'h400;
      #1;
      check("oob.imem_en", 32'(bus.imem_en), 0);
      tick();
      check("oob.halted", 32'(bus.halted), 1);
      check("oob.illegal", 32'(bus.illegal), 1);
      seen_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen_en |= bus.imem_en | bus.issue_valid;
         tick();
      end
      check("oob.activity_seen", 32'(seen_en), 0);

      check("sb.drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
